mbank_porta_arbiter: RTL and testbench

//  Shares port A (R/W) of simple_dual_port_ram between two requesters, each issuing bursts.

---
 rtl/mbank_pkg.sv | 12 +
 rtl/mbank_rr_pick.sv | 17 +
 rtl/simple_dual_port_ram.sv | 24 ++
 rtl/mbank_porta_arbiter.sv | 107 ++++++++++
 tb/tb_mbank_porta_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbank_pkg.sv
// Shared types for the mbank port-A arbiter: FSM states, requester id, one-hot helper.
package mbank_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

  typedef logic req_id_t;

  function automatic logic [1:0] req_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mbank_rr_pick.sv
// Combinational 2-way round-robin pick: on contention the requester that did not win last time wins.
module mbank_rr_pick
  import mbank_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output req_id_t    win,
  output logic       any
);

  always_comb begin
    any = |valid;
    if (valid == 2'b11) win = ~last;
    else                win = valid[1] & ~valid[0];
  end

endmodule

// File: rtl/simple_dual_port_ram.sv
// Dual-port RAM: port A read/write, port B read-only; both reads are registered (1-cycle latency).
// Reads on port A return the old contents when the same address is written in that cycle.
module simple_dual_port_ram #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    douta <= mem[addra];
    doutb <= mem[addrb];
  end

endmodule

// File: rtl/mbank_porta_arbiter.sv
// Shares RAM port A between two burst requesters; first beat issues in the grant cycle,
// read data returns one cycle after each beat; owner stalls hold the burst, no rsp backpressure.
module mbank_porta_arbiter
  import mbank_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 1,
  parameter int LEN_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][LEN_W-1:0]  req_len,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             req_ready,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_last,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   busy,
  output logic                   ram_wea,
  output logic [ADDR_W-1:0]      ram_addra,
  output logic [DATA_W-1:0]      ram_dina,
  input  logic [DATA_W-1:0]      ram_douta
);

  arb_state_e        state;
  req_id_t           owner;
  req_id_t           last_grant;
  logic              own_we;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat_cnt;

  req_id_t           win;
  logic              any;
  req_id_t           cur;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic              is_last;
  logic              issue;

  mbank_rr_pick u_pick (
    .valid (req_valid),
    .last  (last_grant),
    .win   (win),
    .any   (any)
  );

  // In IDLE the winner's live inputs drive the first beat; in BURST the latched context does.
  always_comb begin
    cur      = owner;
    cur_we   = own_we;
    cur_addr = base + ADDR_W'(beat_cnt);
    is_last  = (beat_cnt == len);
    issue    = rst_n & req_valid[owner];
    if (state == ARB_IDLE) begin
      cur      = win;
      cur_we   = req_we[win];
      cur_addr = req_addr[win];
      is_last  = (req_len[win] == '0);
      issue    = rst_n & any;
    end
  end

  assign req_ready = issue ? req_onehot(cur) : 2'b00;
  assign ram_wea   = issue & cur_we;
  assign ram_addra = issue ? cur_addr : '0;
  assign ram_dina  = issue ? req_wdata[cur] : '0;
  assign busy      = (state == ARB_BURST);
  assign rsp_rdata = (|rsp_valid) ? ram_douta : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      own_we     <= 1'b0;
      base       <= '0;
      len        <= '0;
      beat_cnt   <= '0;
      rsp_valid  <= 2'b00;
      rsp_last   <= 1'b0;
    end else begin
      rsp_valid <= (issue && !cur_we) ? req_onehot(cur) : 2'b00;
      rsp_last  <= issue && !cur_we && is_last;
      if (issue) begin
        if (state == ARB_IDLE) begin
          owner  <= cur;
          own_we <= cur_we;
          base   <= cur_addr;
          len    <= req_len[cur];
        end
        if (is_last) begin
          state      <= ARB_IDLE;
          last_grant <= cur;
          beat_cnt   <= '0;
        end else begin
          state    <= ARB_BURST;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbank_porta_arbiter.sv
// Directed bench for mbank_porta_arbiter driving a real simple_dual_port_ram (ADDR_W=2, DATA_W=1).
module tb_mbank_porta_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_we;
  logic [1:0][1:0] req_addr;
  logic [1:0][1:0] req_len;
  logic [1:0][0:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic            rsp_last;
  logic [0:0]      rsp_rdata;
  logic            busy;
  logic            ram_wea;
  logic [1:0]      ram_addra;
  logic [0:0]      ram_dina;
  logic [0:0]      ram_douta;
  logic [1:0]      addrb;
  logic [0:0]      doutb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mbank_porta_arbiter #(.ADDR_W(2), .DATA_W(1), .LEN_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_last  (rsp_last),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta)
  );

  simple_dual_port_ram #(.ADDR_W(2), .DATA_W(1)) u_ram (
    .clk   (clk),
    .wea   (ram_wea),
    .addra (ram_addra),
    .dina  (ram_dina),
    .douta (ram_douta),
    .addrb (addrb),
    .doutb (doutb)
  );

  task automatic clr();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_len   = '0;
    req_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr();
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_last, rsp_rdata, busy, ram_wea, ram_addra, ram_dina} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {req_ready, rsp_valid, rsp_last, rsp_rdata, busy, ram_wea, ram_addra, ram_dina});
    end
    @(negedge clk);
    clr();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, busy, ram_wea} !== 4'd0) begin
      n_err++;
      $display("FAIL idle_no_req: got ready=%b busy=%b wea=%b expected 0", req_ready, busy, ram_wea);
    end
  endtask

  task automatic test_burst_write_read();
    logic [3:0] d;
    d = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid    = 2'b01;
      req_we[0]    = 1'b1;
      req_addr[0]  = 2'(3 * k);
      req_len[0]   = (k == 0) ? 2'd3 : 2'd0;
      req_wdata[0] = d[k];
      #1;
      n_cmp++;
      if ({req_ready, ram_wea, ram_addra, ram_dina, busy} !== {2'b01, 1'b1, 2'(k), d[k], (k != 0)}) begin
        n_err++;
        $display("FAIL wr_beat[%0d]: got ready=%b wea=%b addr=%0d din=%b busy=%b expected 01/1/%0d/%b/%b",
                 k, req_ready, ram_wea, ram_addra, ram_dina, busy, k, d[k], (k != 0));
      end
      n_cmp++;
      if (rsp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL wr_no_rsp[%0d]: got rsp_valid=%b expected 00", k, rsp_valid);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid   = 2'b01;
      req_we[0]   = 1'b0;
      req_addr[0] = (k == 0) ? 2'd0 : 2'd2;
      req_len[0]  = 2'd3;
      #1;
      n_cmp++;
      if ({req_ready, ram_wea, ram_addra, busy} !== {2'b01, 1'b0, 2'(k), (k != 0)}) begin
        n_err++;
        $display("FAIL rd_beat[%0d]: got ready=%b wea=%b addr=%0d busy=%b expected 01/0/%0d/%b",
                 k, req_ready, ram_wea, ram_addra, busy, k, (k != 0));
      end
      if (k > 0) begin
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_last} !== {2'b01, d[k-1], 1'b0}) begin
          n_err++;
          $display("FAIL rd_rsp[%0d]: got v=%b d=%b last=%b expected 01/%b/0",
                   k - 1, rsp_valid, rsp_rdata, rsp_last, d[k-1]);
        end
      end
    end
    @(negedge clk);
    clr();
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_last, req_ready, busy} !== {2'b01, d[3], 1'b1, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL rd_rsp_last: got v=%b d=%b last=%b ready=%b busy=%b expected 01/1/1/00/0",
               rsp_valid, rsp_rdata, rsp_last, req_ready, busy);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_last} !== 3'b000) begin
      n_err++;
      $display("FAIL rd_rsp_done: got v=%b last=%b expected 00/0", rsp_valid, rsp_last);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    logic [1:0] prev;
    do_reset();
    prev = 2'b00;
    for (int c = 0; c < 4; c++) begin
      req_valid   = 2'b11;
      req_we      = 2'b00;
      req_len     = '0;
      req_addr[0] = 2'd0;
      req_addr[1] = 2'd1;
      #1;
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if ({req_ready, busy} !== {exp_rdy, 1'b0}) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got ready=%b busy=%b expected %b/0", c, req_ready, busy, exp_rdy);
      end
      if (c > 0) begin
        n_cmp++;
        if ({rsp_valid, rsp_last} !== {prev, 1'b1}) begin
          n_err++;
          $display("FAIL rr_rsp[%0d]: got v=%b last=%b expected %b/1", c, rsp_valid, rsp_last, prev);
        end
      end
      prev = exp_rdy;
      @(negedge clk);
    end
    clr();
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_last, req_ready} !== {2'b10, 1'b1, 2'b00}) begin
      n_err++;
      $display("FAIL rr_rsp_tail: got v=%b last=%b ready=%b expected 10/1/00", rsp_valid, rsp_last, req_ready);
    end
  endtask

  task automatic test_wrap_write();
    logic [3:0] d;
    logic [1:0] a;
    logic [1:0] rd_addr [4];
    logic [3:0] rd_exp;
    d = 4'b0011;
    rd_addr[0] = 2'd2; rd_addr[1] = 2'd3; rd_addr[2] = 2'd0; rd_addr[3] = 2'd1;
    rd_exp = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid    = 2'b10;
      req_we[1]    = 1'b1;
      req_addr[1]  = (k == 0) ? 2'd2 : 2'd0;
      req_len[1]   = 2'd3;
      req_wdata[1] = d[k];
      #1;
      a = 2'(2 + k);
      n_cmp++;
      if ({req_ready, ram_wea, ram_addra, ram_dina} !== {2'b10, 1'b1, a, d[k]}) begin
        n_err++;
        $display("FAIL wrap_beat[%0d]: got ready=%b wea=%b addr=%0d din=%b expected 10/1/%0d/%b",
                 k, req_ready, ram_wea, ram_addra, ram_dina, a, d[k]);
      end
    end
    @(negedge clk);
    clr();
    for (int k = 0; k < 4; k++) begin
      addrb = rd_addr[k];
      @(negedge clk);
      #1;
      n_cmp++;
      if (doutb !== rd_exp[k]) begin
        n_err++;
        $display("FAIL wrap_portb[%0d]: got %b expected %b", rd_addr[k], doutb, rd_exp[k]);
      end
    end
  endtask

  task automatic test_stall();
    // mem now 0,0,1,1 at addrs 0..3; req0 reads 2,3,0 with a two-cycle gap after beat 1
    logic [1:0] v_seq   [7];
    logic [1:0] rdy_exp [7];
    logic [1:0] addr_exp[7];
    logic [3:0] rsp_exp [7];
    v_seq[0] = 2'b11; rdy_exp[0] = 2'b01; addr_exp[0] = 2'd2; rsp_exp[0] = 4'b0000;
    v_seq[1] = 2'b11; rdy_exp[1] = 2'b01; addr_exp[1] = 2'd3; rsp_exp[1] = 4'b0110;
    v_seq[2] = 2'b10; rdy_exp[2] = 2'b00; addr_exp[2] = 2'd0; rsp_exp[2] = 4'b0110;
    v_seq[3] = 2'b10; rdy_exp[3] = 2'b00; addr_exp[3] = 2'd0; rsp_exp[3] = 4'b0000;
    v_seq[4] = 2'b11; rdy_exp[4] = 2'b01; addr_exp[4] = 2'd0; rsp_exp[4] = 4'b0000;
    v_seq[5] = 2'b11; rdy_exp[5] = 2'b10; addr_exp[5] = 2'd0; rsp_exp[5] = 4'b0101;
    v_seq[6] = 2'b00; rdy_exp[6] = 2'b00; addr_exp[6] = 2'd0; rsp_exp[6] = 4'b1001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid   = v_seq[c];
      req_we      = 2'b00;
      req_addr[0] = 2'd2;
      req_len[0]  = 2'd2;
      req_addr[1] = 2'd0;
      req_len[1]  = 2'd0;
      #1;
      n_cmp++;
      if ({req_ready, ram_wea} !== {rdy_exp[c], 1'b0}) begin
        n_err++;
        $display("FAIL stall_ready[%0d]: got ready=%b wea=%b expected %b/0", c, req_ready, ram_wea, rdy_exp[c]);
      end
      if (rdy_exp[c] != 2'b00) begin
        n_cmp++;
        if (ram_addra !== addr_exp[c]) begin
          n_err++;
          $display("FAIL stall_addr[%0d]: got %0d expected %0d", c, ram_addra, addr_exp[c]);
        end
      end
      n_cmp++;
      if ({rsp_valid, rsp_rdata, rsp_last} !== rsp_exp[c]) begin
        n_err++;
        $display("FAIL stall_rsp[%0d]: got v/d/last=%b expected %b", c,
                 {rsp_valid, rsp_rdata, rsp_last}, rsp_exp[c]);
      end
      if (c == 2 || c == 3) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL stall_busy[%0d]: got %b expected 1", c, busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] rd_addr [3];
    rd_addr[0] = 2'd3; rd_addr[1] = 2'd0; rd_addr[2] = 2'd1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid    = 2'b01;
      req_we[0]    = 1'b1;
      req_addr[0]  = 2'd0;
      req_len[0]   = 2'd3;
      req_wdata[0] = 1'b1;
      #1;
      n_cmp++;
      if ({req_ready, ram_wea, ram_addra} !== {2'b01, 1'b1, 2'(k)}) begin
        n_err++;
        $display("FAIL rstb_beat[%0d]: got ready=%b wea=%b addr=%0d expected 01/1/%0d",
                 k, req_ready, ram_wea, ram_addra, k);
      end
    end
    @(negedge clk);
    rst_n        = 1'b0;
    req_valid    = 2'b11;
    req_wdata[0] = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_last, busy, ram_wea, ram_addra, ram_dina} !== 10'd0) begin
      n_err++;
      $display("FAIL rstb_outputs: got %b expected all zero",
               {req_ready, rsp_valid, rsp_last, busy, ram_wea, ram_addra, ram_dina});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    req_valid   = 2'b11;
    req_we      = 2'b00;
    req_addr[0] = 2'd2;
    req_len     = '0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL rstb_rr_after: got ready=%b expected 01", req_ready);
    end
    @(negedge clk);
    clr();
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_rdata, rsp_last} !== 4'b0111) begin
      n_err++;
      $display("FAIL rstb_addr2_kept: got v/d/last=%b expected 0111", {rsp_valid, rsp_rdata, rsp_last});
    end
    for (int k = 0; k < 3; k++) begin
      addrb = rd_addr[k];
      @(negedge clk);
      #1;
      n_cmp++;
      if (doutb !== 1'b1) begin
        n_err++;
        $display("FAIL rstb_portb[%0d]: got %b expected 1", rd_addr[k], doutb);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       we_seq [4];
    logic [0:0] wd_seq [4];
    logic [3:0] rsp_exp[5];
    we_seq[0] = 1'b1; wd_seq[0] = 1'b0;
    we_seq[1] = 1'b0; wd_seq[1] = 1'b1;
    we_seq[2] = 1'b1; wd_seq[2] = 1'b1;
    we_seq[3] = 1'b0; wd_seq[3] = 1'b0;
    rsp_exp[0] = 4'b0000; rsp_exp[1] = 4'b0000; rsp_exp[2] = 4'b0101;
    rsp_exp[3] = 4'b0000; rsp_exp[4] = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clr();
      if (c < 4) begin
        req_valid    = 2'b01;
        req_we[0]    = we_seq[c];
        req_addr[0]  = 2'd1;
        req_wdata[0] = wd_seq[c];
      end
      #1;
      if (c < 4) begin
        n_cmp++;
        if ({req_ready, ram_wea, ram_addra} !== {2'b01, we_seq[c], 2'd1}) begin
          n_err++;
          $display("FAIL b2b_beat[%0d]: got ready=%b wea=%b addr=%0d expected 01/%b/1",
                   c, req_ready, ram_wea, ram_addra, we_seq[c]);
        end
      end
      n_cmp++;
      if ({rsp_valid, rsp_rdata, rsp_last} !== rsp_exp[c]) begin
        n_err++;
        $display("FAIL b2b_rsp[%0d]: got v/d/last=%b expected %b", c,
                 {rsp_valid, rsp_rdata, rsp_last}, rsp_exp[c]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    addrb = 2'd0;
    test_reset();
    test_burst_write_read();
    test_round_robin();
    test_wrap_write();
    test_stall();
    test_reset_mid_burst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
